sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATASIZE, default 8, data word width in bits.
REQ-002 Parameter ADDRSIZE, default 4, address bits; DEPTH = 2**ADDRSIZE words.
REQ-003 Parameter AFULL_THRESH, default DEPTH-2, walmost_full asserts when count >= this value.
REQ-004 Parameter AEMPTY_THRESH, default 2, ralmost_empty asserts when count <= this value.
REQ-005 The clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be:
- clk  input  1  sole clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- clr  input  1  synchronous flush, same effect as rst on pointers, count and flags
- winc  input  1  write request
- wdata  input  DATASIZE  write data
- wfull  output  1  FIFO holds DEPTH words
- walmost_full  output  1  count >= AFULL_THRESH
- rinc  input  1  read request
- rdata  output  DATASIZE  read data, registered
- rvalid  output  1  rdata holds a newly popped word this cycle
- rempty  output  1  FIFO holds 0 words
- ralmost_empty  output  1  count <= AEMPTY_THRESH
- count  output  ADDRSIZE+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

Function
REQ-007 Write accepted (wen) when winc && !wfull; wdata stored at wptr, wptr increments.
REQ-008 Read accepted (ren) when rinc && !rempty; word at rptr loaded into rdata on the same edge, rptr increments.
REQ-009 Read latency SHALL be 1 cycle: rvalid=1 and rdata valid the cycle after ren; rvalid=0 otherwise; rdata holds its last value when rvalid=0.
REQ-010 wptr/rptr SHALL be ADDRSIZE+1-bit binary; MSB is the wrap bit; memory addressed by the low ADDRSIZE bits; wrap from DEPTH-1 to 0 is seamless.
REQ-011 count, wfull, rempty, walmost_full, ralmost_empty SHALL be registered and updated on the same edge as the accepted operation (no extra lag).
REQ-012 count next = count + wen - ren; wen && ren leaves count unchanged.
REQ-013 Full with winc && rinc: read accepted, write rejected (wfull gates winc using the current-cycle flag); overflow sets.
REQ-014 Empty with winc && rinc: write accepted, read rejected, underflow sets; no write-through/bypass.
REQ-015 overflow sets on winc && wfull; underflow sets on rinc && rempty; both cleared only by rst or clr.
REQ-016 Rejected operations SHALL change neither memory, pointers nor count.
REQ-017 clr has priority over winc/rinc in the same cycle; memory contents need not be cleared.

Reset
REQ-018 On rst (or clr): wptr=0, rptr=0, count=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0 (given AFULL_THRESH>0), rvalid=0, overflow=0, underflow=0; rdata=0 on rst only.
REQ-019 rst mid-operation discards all contents; the first cycle after rst deasserts behaves as an empty FIFO.

Structure
REQ-020 Shared package fifo_pkg SHALL hold default DATASIZE/ADDRSIZE constants and a pointer-width function (ADDRSIZE+1).
REQ-021 Storage SHALL be a sub-module fifomem_sync: single-clock RAM, write port (wen, waddr, wdata), registered read port (ren, raddr, rdata); no reset on the array.
REQ-022 Control (pointers, count, flags, sticky errors) SHALL live in sync_fifo; 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH, checked by elaboration assertion.

Verification
REQ-023 After rst, write 16 words 0x00..0x0F -> wfull=1 on the edge of the 16th write, count=16, walmost_full from count=14.
REQ-024 Full, pulse winc with 0xAA -> overflow=1 and stays; count=16; subsequent 16 reads return 0x00..0x0F, rvalid each cycle after rinc.
REQ-025 Empty, winc=rinc=1 with 0x55 -> count=1, underflow=1, rvalid=0 next cycle; next read returns 0x55.
REQ-026 Count 8, winc=rinc=1 for 40 cycles with incrementing data -> count stays 8, data out in order across pointer wrap.
REQ-027 Count 5, assert clr with winc=1 -> next cycle count=0, rempty=1, overflow/underflow=0, no word written.
REQ-028 Count 10, assert rst with rinc=1 -> next cycle rvalid=0, rdata=0, rempty=1, count=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO family.
// Pointer width carries one extra wrap bit above the memory address.
package fifo_pkg;

   localparam int DEF_DATASIZE = 8;
   localparam int DEF_ADDRSIZE = 4;

   function automatic int ptr_width(input int addrsize);
      return addrsize + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle of sync_fifo.
// master drives requests and data, slave (the FIFO) drives status and read data.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATASIZE = DEF_DATASIZE,
   parameter int ADDRSIZE = DEF_ADDRSIZE
);

   logic                winc;
   logic [DATASIZE-1:0] wdata;
   logic                wfull;
   logic                walmost_full;
   logic                rinc;
   logic [DATASIZE-1:0] rdata;
   logic                rvalid;
   logic                rempty;
   logic                ralmost_empty;
   logic [ADDRSIZE:0]   count;
   logic                overflow;
   logic                underflow;

   modport master (
      output winc, wdata, rinc,
      input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  winc, wdata, rinc,
      output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifomem_sync.sv
// Single-clock RAM: write port plus registered read port, 1-cycle read latency.
// Array is never reset; only the read data register clears on rst.
module fifomem_sync #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wen,
   input  logic [ADDRSIZE-1:0] waddr,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                ren,
   input  logic [ADDRSIZE-1:0] raddr,
   output logic [DATASIZE-1:0] rdata
);

   localparam int DEPTH = 1 << ADDRSIZE;

   logic [DATASIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (ren) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and sticky error bits; reads have 1-cycle latency.
// Writes are refused while full and reads while empty; refused requests only set the sticky flags.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATASIZE      = DEF_DATASIZE,
   parameter int ADDRSIZE      = DEF_ADDRSIZE,
   parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   sync_fifo_if.slave bus
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam int PW    = ptr_width(ADDRSIZE);

   if (!(AEMPTY_THRESH >= 1 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
      $error("sync_fifo: thresholds must satisfy 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
   end

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] cnt;
   logic [PW-1:0] cnt_nxt;
   logic          full;
   logic          empty;
   logic          afull;
   logic          aempty;
   logic          rvalid;
   logic          ovf;
   logic          udf;
   logic          wen;
   logic          ren;

   // Flags gate requests with their current-cycle value; flush or reset overrides both.
   assign wen = bus.winc && !full  && !rst && !clr;
   assign ren = bus.rinc && !empty && !rst && !clr;

   assign cnt_nxt = cnt + {{(PW-1){1'b0}}, wen} - {{(PW-1){1'b0}}, ren};

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr   <= '0;
         rptr   <= '0;
         cnt    <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         afull  <= 1'b0;
         aempty <= 1'b1;
         rvalid <= 1'b0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (wen) begin
            wptr <= wptr + 1'b1;
         end
         if (ren) begin
            rptr <= rptr + 1'b1;
         end
         cnt    <= cnt_nxt;
         full   <= (cnt_nxt == PW'(DEPTH));
         empty  <= (cnt_nxt == '0);
         afull  <= (cnt_nxt >= PW'(AFULL_THRESH));
         aempty <= (cnt_nxt <= PW'(AEMPTY_THRESH));
         rvalid <= ren;
         ovf    <= ovf || (bus.winc && full);
         udf    <= udf || (bus.rinc && empty);
      end
   end

   fifomem_sync #(
      .DATASIZE (DATASIZE),
      .ADDRSIZE (ADDRSIZE)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .wen   (wen),
      .waddr (wptr[ADDRSIZE-1:0]),
      .wdata (bus.wdata),
      .ren   (ren),
      .raddr (rptr[ADDRSIZE-1:0]),
      .rdata (bus.rdata)
   );

   assign bus.count         = cnt;
   assign bus.wfull         = full;
   assign bus.rempty        = empty;
   assign bus.walmost_full  = afull;
   assign bus.ralmost_empty = aempty;
   assign bus.rvalid        = rvalid;
   assign bus.overflow      = ovf;
   assign bus.underflow     = udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int AFT   = DEPTH - 2;
   localparam int AET   = 2;

   logic clk = 1'b0;
   logic rst;
   logic clr;

   sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

   sync_fifo #(
      .DATASIZE (DW),
      .ADDRSIZE (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_rdata;
   logic          m_rvalid;
   logic          m_ovf;
   logic          m_udf;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input logic w, input logic [DW-1:0] d, input logic r,
                               input logic c, input logic rs);
      bit was_full, was_empty;
      if (rs) begin
         mq.delete();
         m_rdata  = '0;
         m_rvalid = 1'b0;
         m_ovf    = 1'b0;
         m_udf    = 1'b0;
      end else if (c) begin
         mq.delete();
         m_rvalid = 1'b0;
         m_ovf    = 1'b0;
         m_udf    = 1'b0;
      end else begin
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         if (w && was_full)  m_ovf = 1'b1;
         if (r && was_empty) m_udf = 1'b1;
         if (r && !was_empty) begin
            m_rdata  = mq.pop_front();
            m_rvalid = 1'b1;
         end else begin
            m_rvalid = 1'b0;
         end
         if (w && !was_full) mq.push_back(d);
      end
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      check_eq("count",         32'(bus.count),         32'(n));
      check_eq("wfull",         32'(bus.wfull),         32'(n == DEPTH));
      check_eq("rempty",        32'(bus.rempty),        32'(n == 0));
      check_eq("walmost_full",  32'(bus.walmost_full),  32'(n >= AFT));
      check_eq("ralmost_empty", 32'(bus.ralmost_empty), 32'(n <= AET));
      check_eq("rvalid",        32'(bus.rvalid),        32'(m_rvalid));
      check_eq("rdata",         32'(bus.rdata),         32'(m_rdata));
      check_eq("overflow",      32'(bus.overflow),      32'(m_ovf));
      check_eq("underflow",     32'(bus.underflow),     32'(m_udf));
   endtask

   // Drive one cycle of stimulus, advance the model, then check after the edge.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c, input logic rs);
      bus.winc  = w;
      bus.wdata = d;
      bus.rinc  = r;
      clr       = c;
      rst       = rs;
      model_update(w, d, r, c, rs);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      bus.winc  = 1'b0;
      bus.wdata = '0;
      bus.rinc  = 1'b0;
      clr       = 1'b0;
      rst       = 1'b1;
      m_rdata   = '0;
      m_rvalid  = 1'b0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      #2;

      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);

      // Fill to full
      for (int i = 0; i < DEPTH; i++) begin
         step(1, DW'(i), 0, 0, 0);
         check_eq("fill_afull", 32'(bus.walmost_full), 32'(i + 1 >= 14));
      end
      check_eq("full_count", 32'(bus.count), 32'd16);
      check_eq("full_flag",  32'(bus.wfull), 32'd1);

      // Write while full, then drain in order
      step(1, 8'hAA, 0, 0, 0);
      check_eq("ovf_set", 32'(bus.overflow), 32'd1);
      check_eq("ovf_cnt", 32'(bus.count), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 1, 0, 0);
         check_eq("drain_data",  32'(bus.rdata),  32'(i));
         check_eq("drain_valid", 32'(bus.rvalid), 32'd1);
      end
      check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);

      // Simultaneous write/read on empty
      step(1, 8'h55, 1, 0, 0);
      check_eq("empty_wr_cnt", 32'(bus.count), 32'd1);
      check_eq("empty_udf",    32'(bus.underflow), 32'd1);
      check_eq("empty_rvalid", 32'(bus.rvalid), 32'd0);
      step(0, 0, 1, 0, 0);
      check_eq("bypass_none", 32'(bus.rdata), 32'h55);

      // Steady occupancy of 8 across pointer wrap
      for (int i = 0; i < 8; i++) step(1, DW'(8'h80 + i), 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         step(1, DW'(8'h88 + i), 1, 0, 0);
         check_eq("steady_cnt", 32'(bus.count), 32'd8);
      end

      // Flush at count 5 with a concurrent write
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      check_eq("pre_clr_cnt", 32'(bus.count), 32'd5);
      step(1, 8'hEE, 0, 1, 0);
      check_eq("clr_cnt",   32'(bus.count), 32'd0);
      check_eq("clr_empty", 32'(bus.rempty), 32'd1);
      step(0, 0, 1, 0, 0);

      // Reset at count 10 with a concurrent read
      for (int i = 0; i < 10; i++) step(1, DW'(8'h30 + i), 0, 0, 0);
      step(0, 0, 1, 0, 1);
      check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check_eq("rst_rdata",  32'(bus.rdata),  32'd0);
      check_eq("rst_count",  32'(bus.count),  32'd0);
      step(0, 0, 1, 0, 0);

      // Random traffic with shifting write/read bias
      for (int i = 0; i < 3000; i++) begin
         int wb, rb;
         wb = (i / 200) % 3 == 0 ? 80 : ((i / 200) % 3 == 1 ? 25 : 50);
         rb = 100 - wb;
         step($urandom_range(99) < wb, DW'($urandom),
              $urandom_range(99) < rb,
              $urandom_range(199) == 0,
              $urandom_range(399) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
